fmrv32im_plic_prio: RTL and testbench

FMRV32IM_PLIC_PRIO -- requirements
Module: fmrv32im_plic_prio

---
 rtl/fmrv32im_plic_prio.sv | 179 +++++++++++++++++
 tb/tb_fmrv32im_plic_prio.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmrv32im_plic_prio.sv
// Priority interrupt controller: per-source pending/enable/edge/priority
// registers, threshold, highest-priority arbitration and claim/complete.
// Ports: CLK, RST (sync, active-high); BUS_WE/BUS_RE/BUS_ADDR/BUS_WDATA
// register access with combinational BUS_RDATA; INT_IN sources (bit i is
// ID i+1); INT_OUT registered request to the core.
// Build option: define PLIC_INPUT_SYNC_EN to add a two-flop input
// synchroniser (adds 2 cycles of INT_IN-to-INT_OUT latency).
module fmrv32im_plic_prio #(
    parameter int NUM_SRC = 32,
    parameter int PRIO_W  = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               BUS_WE,
    input  logic               BUS_RE,
    input  logic [5:0]         BUS_ADDR,
    input  logic [31:0]        BUS_WDATA,
    output logic [31:0]        BUS_RDATA,
    input  logic [NUM_SRC-1:0] INT_IN,
    output logic               INT_OUT
);

    localparam logic [5:0] A_PEND  = 6'h00;
    localparam logic [5:0] A_EN    = 6'h01;
    localparam logic [5:0] A_EDGE  = 6'h02;
    localparam logic [5:0] A_THR   = 6'h03;
    localparam logic [5:0] A_CLAIM = 6'h04;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] edge_cfg;
    logic [NUM_SRC-1:0] in_service;
    logic [NUM_SRC-1:0] int_prev;
    logic [PRIO_W-1:0]  threshold;
    logic [PRIO_W-1:0]  prio [NUM_SRC];
    logic [5:0]         best_q;
    logic               int_out_q;

    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] claim_mask;
    logic [NUM_SRC-1:0] comp_mask;
    logic [NUM_SRC-1:0] w1c_mask;
    logic [NUM_SRC-1:0] set_mask;
    logic [NUM_SRC-1:0] elig;
    logic [5:0]         best_d;
    logic [PRIO_W-1:0]  best_p;

    logic sel_pend;
    logic sel_en;
    logic sel_edge;
    logic sel_thr;
    logic sel_claim;
    logic sel_prio;
    logic claim;

`ifdef PLIC_INPUT_SYNC_EN
    logic [NUM_SRC-1:0] sync1;
    logic [NUM_SRC-1:0] sync2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= INT_IN;
            sync2 <= sync1;
        end
    end

    assign src = sync2;
`else
    assign src = INT_IN;
`endif

    assign sel_pend  = (BUS_ADDR == A_PEND);
    assign sel_en    = (BUS_ADDR == A_EN);
    assign sel_edge  = (BUS_ADDR == A_EDGE);
    assign sel_thr   = (BUS_ADDR == A_THR);
    assign sel_claim = (BUS_ADDR == A_CLAIM);
    assign sel_prio  = BUS_ADDR[5];

    // A claim only takes effect when it actually returns an ID.
    assign claim = BUS_RE && sel_claim && (best_q != 6'd0);

    always_comb begin
        claim_mask = '0;
        comp_mask  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_mask[i] = claim && (best_q == 6'(i + 1));
            // IDs 0 and > NUM_SRC never match any bit.
            comp_mask[i] = BUS_WE && sel_claim
                         && (BUS_WDATA == 32'(i + 1));
        end
    end

    assign w1c_mask = {NUM_SRC{BUS_WE && sel_pend}}
                    & BUS_WDATA[NUM_SRC-1:0];

    // Edge sources may re-pend while in service; level sources are held
    // off from the moment they are claimed until completed.
    assign set_mask = (edge_cfg & src & ~int_prev)
                    | (~edge_cfg & src & ~in_service & ~claim_mask);

    // The source being claimed now is dropped so the next claim never
    // returns the same ID. Strict '>' keeps ties on the lowest ID.
    always_comb begin
        elig   = '0;
        best_d = '0;
        best_p = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            elig[i] = pending[i] && enable[i] && !in_service[i]
                    && !claim_mask[i] && (prio[i] > threshold);
            if (elig[i] && (prio[i] > best_p)) begin
                best_d = 6'(i + 1);
                best_p = prio[i];
            end
        end
    end

    always_comb begin
        BUS_RDATA = '0;
        unique case (1'b1)
            sel_pend:  BUS_RDATA[NUM_SRC-1:0] = pending;
            sel_en:    BUS_RDATA[NUM_SRC-1:0] = enable;
            sel_edge:  BUS_RDATA[NUM_SRC-1:0] = edge_cfg;
            sel_thr:   BUS_RDATA[PRIO_W-1:0]  = threshold;
            sel_claim: BUS_RDATA[5:0]         = best_q;
            sel_prio: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (BUS_ADDR[4:0] == 5'(i)) begin
                        BUS_RDATA[PRIO_W-1:0] = prio[i];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pending    <= '0;
            enable     <= '0;
            edge_cfg   <= '0;
            in_service <= '0;
            int_prev   <= '0;
            threshold  <= '0;
            best_q     <= '0;
            int_out_q  <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                prio[i] <= '0;
            end
        end else begin
            // Sets win over W1C and claim clears.
            pending <= (pending & ~w1c_mask & ~claim_mask) | set_mask;
            // Complete before claim: a same-ID pair leaves it in service.
            in_service <= (in_service & ~comp_mask) | claim_mask;
            int_prev   <= src;
            if (BUS_WE && sel_en) begin
                enable <= BUS_WDATA[NUM_SRC-1:0];
            end
            if (BUS_WE && sel_edge) begin
                edge_cfg <= BUS_WDATA[NUM_SRC-1:0];
            end
            if (BUS_WE && sel_thr) begin
                threshold <= BUS_WDATA[PRIO_W-1:0];
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (BUS_WE && sel_prio && (BUS_ADDR[4:0] == 5'(i))) begin
                    prio[i] <= BUS_WDATA[PRIO_W-1:0];
                end
            end
            best_q    <= best_d;
            int_out_q <= (best_d != 6'd0);
        end
    end

    assign INT_OUT = int_out_q;

endmodule

// File: tb/tb_fmrv32im_plic_prio.sv
// Bench for fmrv32im_plic_prio: register table, directed interrupt
// sequences, and randomized traffic against a behavioural model.
module tb_fmrv32im_plic_prio;

`ifdef PLIC_INPUT_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic        CLK;
    logic        RST;
    logic        BUS_WE;
    logic        BUS_RE;
    logic [5:0]  BUS_ADDR;
    logic [31:0] BUS_WDATA;
    logic [31:0] BUS_RDATA;
    logic [31:0] INT_IN;
    logic        INT_OUT;

    int checks = 0;
    int errors = 0;

    fmrv32im_plic_prio dut (
        .CLK       (CLK),
        .RST       (RST),
        .BUS_WE    (BUS_WE),
        .BUS_RE    (BUS_RE),
        .BUS_ADDR  (BUS_ADDR),
        .BUS_WDATA (BUS_WDATA),
        .BUS_RDATA (BUS_RDATA),
        .INT_IN    (INT_IN),
        .INT_OUT   (INT_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        bit        we;
        bit        re;
        bit [5:0]  addr;
        bit [31:0] wdata;
        bit        chk;
        bit [31:0] exp;
    } vec_t;

    vec_t tbl [20];

    // Behavioural model state
    bit [31:0] m_pend, m_en, m_edge, m_ins, m_prev, m_s1, m_s2;
    int        m_prio [32];
    int        m_thr;
    int        m_best;
    bit        m_int;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_bus();
        BUS_WE    = 1'b0;
        BUS_RE    = 1'b0;
        BUS_ADDR  = 6'h00;
        BUS_WDATA = 32'h0;
    endtask

    task automatic do_reset();
        idle_bus();
        INT_IN = 32'h0;
        RST    = 1'b1;
        cyc();
        RST    = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        BUS_WE    = 1'b1;
        BUS_ADDR  = a;
        BUS_WDATA = d;
        cyc();
        idle_bus();
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        BUS_ADDR = a;
        #1;
        d = BUS_RDATA;
        BUS_ADDR = 6'h00;
    endtask

    task automatic do_claim(output logic [31:0] id);
        BUS_RE   = 1'b1;
        BUS_ADDR = 6'h04;
        #1;
        id = BUS_RDATA;
        cyc();
        idle_bus();
    endtask

    task automatic model_reset();
        m_pend = 0; m_en = 0; m_edge = 0; m_ins = 0;
        m_prev = 0; m_s1 = 0; m_s2 = 0;
        m_thr = 0; m_best = 0; m_int = 0;
        for (int i = 0; i < 32; i++) m_prio[i] = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] a);
        if (a[5]) return 32'(m_prio[a[4:0]]);
        case (a)
            6'h00:   return m_pend;
            6'h01:   return m_en;
            6'h02:   return m_edge;
            6'h03:   return 32'(m_thr);
            6'h04:   return 32'(m_best);
            default: return 32'h0;
        endcase
    endfunction

    // One clock of the controller, stated source by source.
    task automatic model_step();
        bit [31:0] src;
        int claim_id, comp_id, best, bp, wd;
        bit [31:0] np, ni;
        src = (SYNC > 0) ? m_s2 : INT_IN;
        claim_id = (BUS_RE && BUS_ADDR == 6'h04 && m_best != 0) ? m_best : 0;
        comp_id = 0;
        if (BUS_WE && BUS_ADDR == 6'h04 && BUS_WDATA >= 1
            && BUS_WDATA <= 32 && m_ins[BUS_WDATA - 1])
            comp_id = int'(BUS_WDATA);
        best = 0;
        bp   = 0;
        for (int i = 0; i < 32; i++) begin
            if (m_pend[i] && m_en[i] && !m_ins[i] && claim_id != i + 1
                && m_prio[i] > m_thr && m_prio[i] > bp) begin
                best = i + 1;
                bp   = m_prio[i];
            end
        end
        np = m_pend;
        ni = m_ins;
        for (int i = 0; i < 32; i++) begin
            if (BUS_WE && BUS_ADDR == 6'h00 && BUS_WDATA[i]) np[i] = 0;
            if (claim_id == i + 1) np[i] = 0;
            if (m_edge[i]) begin
                if (src[i] && !m_prev[i]) np[i] = 1;
            end else begin
                if (src[i] && !m_ins[i] && claim_id != i + 1) np[i] = 1;
            end
            if (comp_id == i + 1) ni[i] = 0;
            if (claim_id == i + 1) ni[i] = 1;
        end
        m_pend = np;
        m_ins  = ni;
        m_prev = src;
        m_s2   = m_s1;
        m_s1   = INT_IN;
        wd = int'(BUS_WDATA % 8);
        if (BUS_WE) begin
            if (BUS_ADDR == 6'h01) m_en = BUS_WDATA;
            if (BUS_ADDR == 6'h02) m_edge = BUS_WDATA;
            if (BUS_ADDR == 6'h03) m_thr = wd;
            if (BUS_ADDR[5]) m_prio[BUS_ADDR[4:0]] = wd;
        end
        m_best = best;
        m_int  = (best != 0);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] id;
        int          op;

        tbl[0]  = '{0, 0, 6'h00, 32'h0,        1, 32'h0};
        tbl[1]  = '{0, 0, 6'h01, 32'h0,        1, 32'h0};
        tbl[2]  = '{0, 0, 6'h03, 32'h0,        1, 32'h0};
        tbl[3]  = '{0, 1, 6'h04, 32'h0,        1, 32'h0};
        tbl[4]  = '{0, 0, 6'h25, 32'h0,        1, 32'h0};
        tbl[5]  = '{1, 0, 6'h01, 32'hDEADBEEF, 0, 32'h0};
        tbl[6]  = '{0, 0, 6'h01, 32'h0,        1, 32'hDEADBEEF};
        tbl[7]  = '{1, 0, 6'h03, 32'hFFFFFFFD, 0, 32'h0};
        tbl[8]  = '{0, 0, 6'h03, 32'h0,        1, 32'h5};
        tbl[9]  = '{1, 0, 6'h25, 32'h1E,       0, 32'h0};
        tbl[10] = '{0, 0, 6'h25, 32'h0,        1, 32'h6};
        tbl[11] = '{1, 0, 6'h3F, 32'hF,        0, 32'h0};
        tbl[12] = '{0, 0, 6'h3F, 32'h0,        1, 32'h7};
        tbl[13] = '{1, 0, 6'h05, 32'h1234,     0, 32'h0};
        tbl[14] = '{0, 0, 6'h05, 32'h0,        1, 32'h0};
        tbl[15] = '{1, 0, 6'h02, 32'hF0,       0, 32'h0};
        tbl[16] = '{0, 0, 6'h02, 32'h0,        1, 32'hF0};
        tbl[17] = '{1, 0, 6'h04, 32'h5,        0, 32'h0};
        tbl[18] = '{0, 0, 6'h10, 32'h0,        1, 32'h0};
        tbl[19] = '{0, 0, 6'h00, 32'h0,        1, 32'h0};

        idle_bus();
        INT_IN = 32'h0;
        RST = 1'b1;
        cyc();
        cyc();
        RST = 1'b0;
        chk("reset_int_out", {31'h0, INT_OUT}, 32'h0);

        // Register access table
        for (int k = 0; k < 20; k++) begin
            BUS_WE    = tbl[k].we;
            BUS_RE    = tbl[k].re;
            BUS_ADDR  = tbl[k].addr;
            BUS_WDATA = tbl[k].wdata;
            #1;
            if (tbl[k].chk)
                chk($sformatf("table_%0d", k), BUS_RDATA, tbl[k].exp);
            cyc();
        end
        idle_bus();

        // Single edge source: latency, claim, drop
        do_reset();
        wr(6'h02, 32'h1);
        wr(6'h01, 32'h1);
        wr(6'h20, 32'h3);
        INT_IN = 32'h1;
        cyc();
        INT_IN = 32'h0;
        repeat (SYNC) cyc();
        chk("lat_early", {31'h0, INT_OUT}, 32'h0);
        cyc();
        chk("lat_int_out", {31'h0, INT_OUT}, 32'h1);
        do_claim(id);
        chk("claim_src0", id, 32'h1);
        chk("int_drop", {31'h0, INT_OUT}, 32'h0);

        // Equal priority: lowest ID first, no repeat
        do_reset();
        wr(6'h02, 32'hFFFFFFFF);
        wr(6'h01, 32'hFFFFFFFF);
        wr(6'h22, 32'h5);
        wr(6'h27, 32'h5);
        INT_IN = 32'h84;
        cyc();
        INT_IN = 32'h0;
        repeat (1 + SYNC) cyc();
        do_claim(id);
        chk("tie_first", id, 32'h3);
        do_claim(id);
        chk("tie_second", id, 32'h8);
        do_claim(id);
        chk("tie_third", id, 32'h0);

        // Threshold gating
        do_reset();
        wr(6'h02, 32'h2);
        wr(6'h01, 32'h2);
        wr(6'h21, 32'h4);
        wr(6'h03, 32'h4);
        INT_IN = 32'h2;
        cyc();
        INT_IN = 32'h0;
        repeat (3 + SYNC) cyc();
        chk("thr_block", {31'h0, INT_OUT}, 32'h0);
        wr(6'h03, 32'h3);
        cyc();
        chk("thr_pass", {31'h0, INT_OUT}, 32'h1);

        // Level source held through service
        do_reset();
        wr(6'h01, 32'h20);
        wr(6'h25, 32'h2);
        INT_IN = 32'h20;
        repeat (2 + SYNC) cyc();
        do_claim(id);
        chk("level_claim", id, 32'h6);
        repeat (3) cyc();
        chk("level_held", {31'h0, INT_OUT}, 32'h0);
        rd(6'h00, v);
        chk("level_pend_clr", v & 32'h20, 32'h0);
        wr(6'h04, 32'h6);
        cyc();
        rd(6'h00, v);
        chk("level_repend", v & 32'h20, 32'h20);
        cyc();
        do_claim(id);
        chk("level_reclaim", id, 32'h6);
        INT_IN = 32'h0;

        // W1C racing a new edge
        do_reset();
        wr(6'h02, 32'h10);
        INT_IN = 32'h10;
        repeat (SYNC) cyc();
        wr(6'h00, 32'h10);
        rd(6'h00, v);
        chk("w1c_race", v & 32'h10, 32'h10);
        wr(6'h00, 32'h10);
        rd(6'h00, v);
        chk("w1c_plain", v & 32'h10, 32'h0);
        INT_IN = 32'h0;

        // Reset while in service
        do_reset();
        wr(6'h02, 32'h2);
        wr(6'h01, 32'h2);
        wr(6'h21, 32'h1);
        INT_IN = 32'h2;
        cyc();
        INT_IN = 32'h0;
        repeat (1 + SYNC) cyc();
        do_claim(id);
        chk("rst_pre_claim", id, 32'h2);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        chk("rst_int_out", {31'h0, INT_OUT}, 32'h0);
        for (int a = 0; a < 5; a++) begin
            rd(6'(a), v);
            chk($sformatf("rst_reg_%0d", a), v, 32'h0);
        end
        rd(6'h21, v);
        chk("rst_prio1", v, 32'h0);
        wr(6'h02, 32'h2);
        wr(6'h01, 32'h2);
        wr(6'h21, 32'h1);
        INT_IN = 32'h2;
        cyc();
        INT_IN = 32'h0;
        repeat (1 + SYNC) cyc();
        do_claim(id);
        chk("rst_reclaim", id, 32'h2);

        // Randomized traffic against the model
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            idle_bus();
            RST = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) INT_IN = $urandom;
            BUS_ADDR  = 6'($urandom_range(0, 63));
            BUS_WDATA = $urandom;
            op = $urandom_range(0, 9);
            case (op)
                4: BUS_RE = 1'b1;
                5: begin
                    BUS_WE   = 1'b1;
                    BUS_ADDR = 6'($urandom_range(0, 3));
                end
                6: begin
                    BUS_RE   = 1'b1;
                    BUS_ADDR = 6'h04;
                end
                7: begin
                    BUS_WE    = 1'b1;
                    BUS_ADDR  = 6'h04;
                    BUS_WDATA = $urandom_range(0, 34);
                end
                8: begin
                    BUS_WE    = 1'b1;
                    BUS_RE    = 1'b1;
                    BUS_ADDR  = 6'h04;
                    BUS_WDATA = $urandom_range(0, 34);
                end
                9: begin
                    BUS_WE   = 1'b1;
                    BUS_ADDR = 6'h20 | 6'($urandom_range(0, 31));
                end
                default: ;
            endcase
            #1;
            chk($sformatf("rand_rdata_%0d", n), BUS_RDATA,
                model_read(BUS_ADDR));
            chk($sformatf("rand_int_%0d", n), {31'h0, INT_OUT},
                {31'h0, m_int});
            if (RST) model_reset();
            else model_step();
            cyc();
        end
        RST = 1'b0;
        idle_bus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
